// File: rtl/endpoint_tx.sv
// Endpoint transmit stage: turns a packet descriptor plus payload words into a
// head flit and body flits for switch port 0, paced by per-VC credits.
package endpoint_tx_pkg;
  typedef struct packed {
    logic [3:0]  vc;
    logic [3:0]  id;
    logic [7:0]  req;
    logic [31:0] payload;
  } flit_t;
endpackage

// One downstream-buffer credit counter; saturates at BUFFER_SIZE on grants.
module endpoint_tx_credit #(
  parameter int BUFFER_SIZE = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic send,
  input  logic grant,
  output logic avail
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (send && !grant)
      cnt_d = cnt_q - CW'(1);
    else if (grant && !send && cnt_q != FULL)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= FULL;
    else        cnt_q <= cnt_d;
  end

  assign avail = (cnt_q != '0);
endmodule

module endpoint_tx
  import endpoint_tx_pkg::*;
#(
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int NODE        = 1,
  parameter int TOTAL_NODES = 4,
  parameter int MAX_PKT_LEN = 128,
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [7:0]         pkt_dest,
  input  logic [VW-1:0]      pkt_vc,
  input  logic [7:0]         pkt_len,
  input  logic               word_valid,
  input  logic [31:0]        word_data,
  output logic               word_ready,
  output flit_t              out,
  output logic               data_ready_out,
  input  logic [NUM_VCS-1:0] credit_granted,
  output logic [NUM_VCS-1:0] credit_avail,
  output logic               err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  localparam logic [7:0] NODE_ID  = 8'(NODE);
  localparam logic [7:0] LEN_MAX  = 8'(MAX_PKT_LEN);
  localparam logic [7:0] DEST_MAX = 8'(TOTAL_NODES);

  logic [1:0]    state_d, state_q;
  logic [7:0]    dest_d, dest_q;
  logic [VW-1:0] vc_d, vc_q;
  logic [7:0]    len_d, len_q;
  logic [7:0]    rem_d, rem_q;
  logic [3:0]    id_d, id_q;
  flit_t         out_d, out_q;
  logic          dro_d, dro_q;
  logic          err_d, err_q;

  logic               flit_send;
  logic               cur_avail;
  logic               bad_desc;
  logic [NUM_VCS-1:0] send_vec;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    endpoint_tx_credit #(.BUFFER_SIZE(BUFFER_SIZE)) u_credit (
      .clk   (clk),
      .n_rst (n_rst),
      .send  (send_vec[v]),
      .grant (credit_granted[v]),
      .avail (credit_avail[v])
    );
  end

  assign cur_avail = credit_avail[vc_q];
  assign bad_desc  = (pkt_len == 8'd0) || (pkt_len > LEN_MAX) ||
                     (pkt_dest == 8'd0) || (pkt_dest > DEST_MAX);

  always_comb begin
    send_vec = '0;
    for (int v = 0; v < NUM_VCS; v++)
      send_vec[v] = flit_send && (vc_q == VW'(v));
  end

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    vc_d      = vc_q;
    len_d     = len_q;
    rem_d     = rem_q;
    id_d      = id_q;
    out_d     = out_q;
    dro_d     = 1'b0;
    err_d     = 1'b0;
    flit_send = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          if (bad_desc) begin
            err_d = 1'b1;
          end else begin
            dest_d  = pkt_dest;
            vc_d    = pkt_vc;
            len_d   = pkt_len;
            rem_d   = pkt_len;
            state_d = S_HEAD;
          end
        end
      end
      S_HEAD: begin
        if (cur_avail) begin
          flit_send     = 1'b1;
          dro_d         = 1'b1;
          out_d.vc      = 4'(vc_q);
          out_d.id      = id_q;
          out_d.req     = dest_q;
          out_d.payload = {8'h00, dest_q, NODE_ID, len_q};
          state_d       = S_BODY;
        end
      end
      S_BODY: begin
        if (word_valid && cur_avail) begin
          flit_send     = 1'b1;
          dro_d         = 1'b1;
          out_d.vc      = 4'(vc_q);
          out_d.id      = id_q;
          out_d.req     = dest_q;
          out_d.payload = word_data;
          rem_d         = rem_q - 8'd1;
          // The last word closes the packet and retires its id.
          if (rem_q == 8'd1) begin
            state_d = S_IDLE;
            id_d    = id_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      vc_q    <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      out_q   <= '0;
      dro_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      vc_q    <= vc_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      out_q   <= out_d;
      dro_q   <= dro_d;
      err_q   <= err_d;
    end
  end

  assign pkt_ready      = (state_q == S_IDLE);
  assign word_ready     = (state_q == S_BODY) && cur_avail;
  assign out            = out_q;
  assign data_ready_out = dro_q;
  assign err            = err_q;
endmodule

// File: tb/tb_endpoint_tx.sv
// Directed bench for endpoint_tx: a flit-queue/credit model checked every
// cycle, plus literal timing and payload expectations for each scenario.
module tb_endpoint_tx;
  import endpoint_tx_pkg::*;

  localparam int BS     = 8;
  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [7:0]  pkt_dest = '0;
  logic [0:0]  pkt_vc = '0;
  logic [7:0]  pkt_len = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready;
  flit_t       out;
  logic        data_ready_out;
  logic [1:0]  credit_granted = '0;
  logic [1:0]  credit_avail;
  logic        err;

  endpoint_tx dut (
    .clk(clk), .n_rst(n_rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dest(pkt_dest), .pkt_vc(pkt_vc), .pkt_len(pkt_len),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .out(out), .data_ready_out(data_ready_out),
    .credit_granted(credit_granted), .credit_avail(credit_avail), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    flit_t f;
    bit    head;
  } exp_t;

  exp_t        q[$];
  flit_t       obs[$];
  time         pulse_t[$];
  time         err_t[$];
  logic [3:0]  head_ids[$];
  int          mc[2];
  logic [1:0]  pend_grant;
  logic [3:0]  mid = '0;
  logic [31:0] wbuf[256];
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Model: every accepted descriptor yields a head then len bodies, in order.
  task automatic push_exp(input logic [7:0] d, input logic [0:0] vc, input logic [7:0] len);
    exp_t e;
    e.head = 1'b1;
    e.f.vc = 4'(vc); e.f.id = mid; e.f.req = d;
    e.f.payload = {8'h00, d, 8'h01, len};
    q.push_back(e);
    e.head = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      e.f.payload = wbuf[i];
      q.push_back(e);
    end
    mid = mid + 4'd1;
  endtask

  task automatic send_desc(input logic [7:0] d, input logic [0:0] vc, input logic [7:0] len,
                           output time t);
    int n = 0;
    pkt_valid = 1'b1; pkt_dest = d; pkt_vc = vc; pkt_len = len;
    @(negedge clk);
    while (!pkt_ready && n < BUDGET) begin n++; @(negedge clk); end
    if (!pkt_ready) fail("desc_timeout");
    t = $time;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    word_valid = 1'b1; word_data = w;
    @(negedge clk);
    while (!word_ready && n < BUDGET) begin n++; @(negedge clk); end
    if (!word_ready) fail("word_timeout");
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] d, input logic [0:0] vc, input logic [7:0] len,
                          input logic g_on_head, output time t);
    push_exp(d, vc, len);
    send_desc(d, vc, len, t);
    credit_granted[vc] = g_on_head;
    @(posedge clk); #1;
    credit_granted[vc] = 1'b0;
    for (int i = 0; i < int'(len); i++) send_word(wbuf[i]);
  endtask

  task automatic give_grants(input logic [1:0] mask, input int n);
    credit_granted = credit_granted | mask;
    repeat (n) @(posedge clk);
    #1;
    credit_granted = credit_granted & ~mask;
  endtask

  // Per-cycle compare: flit content/order, credit arithmetic, credit_avail.
  initial begin
    exp_t e;
    int   sv;
    mc[0] = BS; mc[1] = BS; pend_grant = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        q.delete();
        mc[0] = BS; mc[1] = BS;
      end else begin
        sv = -1;
        if (data_ready_out) begin
          obs.push_back(out);
          pulse_t.push_back($time);
          if (q.size() == 0) fail("unexpected_flit");
          else begin
            e = q.pop_front();
            chk("flit", 64'(out), 64'(e.f));
            if (e.head) head_ids.push_back(out.id);
            sv = int'(e.f.vc);
            chk("credit_before_send", 64'(mc[sv] > 0), 64'd1);
          end
        end
        for (int v = 0; v < 2; v++) begin
          if (sv == v && !pend_grant[v]) mc[v] = mc[v] - 1;
          else if (sv != v && pend_grant[v]) mc[v] = (mc[v] < BS) ? mc[v] + 1 : BS;
        end
      end
      if (err) err_t.push_back($time);
      chk("credit_cnt0", 64'(dut.g_vc[0].u_credit.cnt_q), 64'(mc[0]));
      chk("credit_cnt1", 64'(dut.g_vc[1].u_credit.cnt_q), 64'(mc[1]));
      chk("credit_avail", 64'(credit_avail), {62'd0, mc[1] != 0, mc[0] != 0});
      pend_grant = n_rst ? credit_granted : 2'b00;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  logic [7:0] bad_dest[4] = '{8'd2, 8'd2, 8'd0, 8'd5};
  logic [7:0] bad_len[4]  = '{8'd0, 8'd129, 8'd1, 8'd1};

  initial begin
    time td, tg;
    int  b, e0;

    repeat (2) @(negedge clk);
    chk("rst_pkt_ready", pkt_ready, 1);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_dro", data_ready_out, 0);
    chk("rst_out", 64'(out), 0);
    chk("rst_err", err, 0);
    chk("rst_credit_avail", credit_avail, 2'b11);
    sync(); n_rst = 1'b1;
    tick();
    chk("idle_pkt_ready", pkt_ready, 1);
    chk("idle_word_ready", word_ready, 0);

    // Basic two-word packet on VC0.
    sync();
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
    b = obs.size();
    send_pkt(8'd3, 1'b0, 8'd2, 1'b0, td);
    tick();
    chk("p1_back_idle", pkt_ready, 1);
    chk("p1_nflits", obs.size() - b, 3);
    if (obs.size() >= b + 3) begin
      chk("p1_head_payload", obs[b].payload, 32'h00030102);
      chk("p1_head_id", obs[b].id, 0);
      chk("p1_head_req", obs[b].req, 3);
      chk("p1_body0", obs[b+1].payload, 32'hA5A5A5A5);
      chk("p1_body1", obs[b+2].payload, 32'h5A5A5A5A);
      chk("p1_head_lat", 64'(pulse_t[b] - td), 20);
      chk("p1_gap1", 64'(pulse_t[b+1] - pulse_t[b]), 10);
      chk("p1_gap2", 64'(pulse_t[b+2] - pulse_t[b+1]), 10);
    end
    chk("p1_model_credit0", mc[0], 5);

    // Restore VC0, then hammer both VCs at saturation.
    sync();
    give_grants(2'b01, 3);
    give_grants(2'b11, 2);
    tick();
    chk("sat_credit0", mc[0], 8);
    chk("sat_credit1", mc[1], 8);

    // Eight-body packet on VC1 stalls after 8 flits until one grant.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE0000 + i;
    sync();
    b = obs.size();
    tg = 0;
    fork
      send_pkt(8'd2, 1'b1, 8'd8, 1'b0, td);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (credit_avail[1] && k < BUDGET) begin k++; @(negedge clk); end
        chk("vc1_drained", credit_avail[1], 0);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_word_ready", word_ready, 0);
        chk("stall_nflits", obs.size() - b, 8);
        chk("stall_model_credit1", mc[1], 0);
        sync();
        credit_granted[1] = 1'b1;
        @(negedge clk); tg = $time;
        sync();
        credit_granted[1] = 1'b0;
      end
    join
    tick();
    chk("vc1_nflits", obs.size() - b, 9);
    chk("vc1_last_lat", 64'(pulse_t[$] - tg), 20);
    chk("vc1_last_payload", obs[$].payload, 32'hC0DE0007);
    sync();
    give_grants(2'b10, 8);

    // Grant coinciding with the head send leaves VC0 unchanged.
    wbuf[0] = 32'hDEADBEEF;
    send_pkt(8'd4, 1'b0, 8'd1, 1'b1, td);
    tick();
    chk("same_cycle_credit0", mc[0], 7);
    sync();
    give_grants(2'b01, 1);

    // Rejected descriptors.
    for (int i = 0; i < 4; i++) begin
      e0 = err_t.size();
      b  = obs.size();
      send_desc(bad_dest[i], 1'b0, bad_len[i], td);
      tick();
      tick();
      chk("bad_err_count", err_t.size() - e0, 1);
      if (err_t.size() > e0) chk("bad_err_lat", 64'(err_t[$] - td), 10);
      chk("bad_pkt_ready", pkt_ready, 1);
      chk("bad_no_flits", obs.size() - b, 0);
      sync();
    end

    // Fresh reset, then 17 packets to wrap the id.
    n_rst = 1'b0;
    tick();
    sync();
    n_rst = 1'b1; mid = '0;
    head_ids.delete();
    for (int i = 0; i < 17; i++) begin
      wbuf[0] = 32'h1000 + i;
      send_pkt(8'(1 + i % 4), 1'(i % 2), 8'd1, 1'b0, td);
      give_grants(2'(1 << (i % 2)), 2);
    end
    tick();
    chk("wrap_npkts", head_ids.size(), 17);
    if (head_ids.size() == 17) begin
      chk("wrap_id0", head_ids[0], 0);
      chk("wrap_id15", head_ids[15], 15);
      chk("wrap_id16", head_ids[16], 0);
    end

    // Reset in the middle of a len=4 body.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hBEEF0000 + i;
    sync();
    push_exp(8'd4, 1'b1, 8'd4);
    send_desc(8'd4, 1'b1, 8'd4, td);
    sync();
    send_word(wbuf[0]);
    send_word(wbuf[1]);
    n_rst = 1'b0;
    word_valid = 1'b0;
    tick();
    chk("mid_rst_pkt_ready", pkt_ready, 1);
    chk("mid_rst_word_ready", word_ready, 0);
    chk("mid_rst_dro", data_ready_out, 0);
    chk("mid_rst_out", 64'(out), 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_avail", credit_avail, 2'b11);
    sync();
    n_rst = 1'b1; mid = '0;
    head_ids.delete();
    b = obs.size();
    for (int i = 0; i < 3; i++) wbuf[i] = 32'h7777000 + i;
    send_pkt(8'd1, 1'b1, 8'd3, 1'b0, td);
    tick();
    chk("post_rst_nflits", obs.size() - b, 4);
    if (head_ids.size() > 0) chk("post_rst_id", head_ids[0], 0);
    else fail("post_rst_no_head");
    chk("post_rst_model_credit1", mc[1], 4);

    tick();
    chk("queue_drained", q.size(), 0);
    chk("total_err_pulses", err_t.size(), 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
